f2f_track_decoder: RTL

F2F_TRACK_DECODER -- requirements
Module: f2f_track_decoder

---
 rtl/f2f_track_decoder.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/f2f_track_decoder.sv
// F2F (Aiken biphase) magnetic-stripe track decoder: clock recovery, sync lock,
// start-sentinel hunt, 4+parity character framing and LRC check.
module f2f_track_decoder #(
  parameter int unsigned SYNC_ZEROS   = 8,
  parameter int unsigned MIN_INTERVAL = 4,
  parameter int unsigned TIMEOUT      = 20'hFFFFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       f2f_in,
  output logic       locked,
  output logic [3:0] char_data,
  output logic       char_valid,
  output logic       char_perr,
  output logic       track_done,
  output logic       lrc_err,
  output logic       abort
);
  localparam int unsigned CW = 20;
  localparam int unsigned ZW = 16;
  localparam logic [4:0] START_SENT = 5'b01011;
  localparam logic [3:0] END_SENT   = 4'hF;

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_HUNT, S_DATA, S_LRC} state_t;
  state_t state, state_nxt;

  logic [2:0]    sync_q;
  logic [CW-1:0] cnt, cnt_d, t_ref, t_ref_d, half_len, half_len_d, thresh;
  logic          half_pend, half_pend_d, have_ref, have_ref_d;
  logic [ZW-1:0] zero_cnt, zero_cnt_d, zero_nxt;
  logic [4:0]    window, window_d, win_nxt;
  logic [2:0]    bit_cnt, bit_cnt_d;
  logic [3:0]    lrc_acc, lrc_acc_d;
  logic          locked_d, char_valid_d, char_perr_d, track_done_d, lrc_err_d, abort_d;
  logic [3:0]    char_data_d;
  logic          edge_det, acc_edge, full_cell, in_track, frame_err, bit_ev, char_end;
  logic          timeout, sync_done;

  // Edge = change of the synchronized level; short intervals are glitches
  assign edge_det  = sync_q[1] ^ sync_q[2];
  assign acc_edge  = edge_det && (cnt >= CW'(MIN_INTERVAL));
  assign thresh    = t_ref - (t_ref >> 2);
  assign full_cell = cnt >= thresh;
  assign in_track  = (state == S_HUNT) || (state == S_DATA) || (state == S_LRC);
  assign frame_err = in_track && acc_edge && full_cell && half_pend;
  assign bit_ev    = in_track && acc_edge && (full_cell ^ half_pend);
  assign win_nxt   = {~full_cell, window[4:1]};
  assign char_end  = bit_ev && (bit_cnt == 3'd4);
  assign timeout   = !acc_edge && (cnt >= CW'(TIMEOUT));
  assign zero_nxt  = !have_ref ? ZW'(1) : (full_cell ? zero_cnt + ZW'(1) : '0);
  assign sync_done = acc_edge && (zero_nxt == ZW'(SYNC_ZEROS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (acc_edge) state_nxt = S_SYNC;
      S_SYNC: begin
        if (sync_done)    state_nxt = S_HUNT;
        else if (timeout) state_nxt = S_IDLE;
      end
      S_HUNT: begin
        if (frame_err)                            state_nxt = S_IDLE;
        else if (bit_ev && win_nxt == START_SENT) state_nxt = S_DATA;
        else if (timeout)                         state_nxt = S_IDLE;
      end
      S_DATA: begin
        if (frame_err)                                state_nxt = S_IDLE;
        else if (char_end && win_nxt[3:0] == END_SENT) state_nxt = S_LRC;
        else if (timeout)                             state_nxt = S_IDLE;
      end
      S_LRC: begin
        if (frame_err || char_end || timeout) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    cnt_d        = acc_edge ? '0 : ((&cnt) ? cnt : cnt + CW'(1));
    t_ref_d      = t_ref;
    half_len_d   = half_len;
    half_pend_d  = half_pend;
    have_ref_d   = have_ref;
    zero_cnt_d   = zero_cnt;
    window_d     = window;
    bit_cnt_d    = bit_cnt;
    lrc_acc_d    = lrc_acc;
    locked_d     = locked;
    char_data_d  = char_data;
    char_valid_d = 1'b0;
    char_perr_d  = char_perr;
    track_done_d = 1'b0;
    lrc_err_d    = lrc_err;
    abort_d      = abort;
    case (state)
      S_IDLE: begin
        if (acc_edge) begin
          zero_cnt_d = '0;
          have_ref_d = 1'b0;
        end
      end
      S_SYNC: begin
        if (acc_edge) begin
          t_ref_d    = (!have_ref || full_cell) ? cnt : {cnt[CW-2:0], 1'b0};
          have_ref_d = 1'b1;
          zero_cnt_d = zero_nxt;
          if (sync_done) begin
            locked_d    = 1'b1;
            window_d    = '0;
            half_pend_d = 1'b0;
          end
        end
      end
      S_HUNT, S_DATA, S_LRC: begin
        if (frame_err) begin
          abort_d      = 1'b1;
          track_done_d = 1'b1;
        end else if (acc_edge) begin
          if (full_cell) begin
            t_ref_d = cnt;
          end else if (!half_pend) begin
            half_len_d  = cnt;
            half_pend_d = 1'b1;
          end else begin
            t_ref_d     = half_len + cnt;
            half_pend_d = 1'b0;
          end
        end
        if (bit_ev) begin
          window_d  = win_nxt;
          bit_cnt_d = bit_cnt + 3'd1;
          if (state == S_HUNT) begin
            if (win_nxt == START_SENT) begin
              char_valid_d = 1'b1;
              char_data_d  = START_SENT[3:0];
              char_perr_d  = 1'b0;
              lrc_err_d    = 1'b0;
              abort_d      = 1'b0;
              lrc_acc_d    = START_SENT[3:0];
              bit_cnt_d    = '0;
            end
          end else if (char_end) begin
            bit_cnt_d    = '0;
            char_valid_d = 1'b1;
            char_data_d  = win_nxt[3:0];
            char_perr_d  = ~(^win_nxt);
            if (state == S_DATA) begin
              lrc_acc_d = lrc_acc ^ win_nxt[3:0];
            end else begin
              lrc_err_d    = (win_nxt[3:0] != lrc_acc) || ~(^win_nxt);
              track_done_d = 1'b1;
            end
          end
        end
        if (timeout && state != S_HUNT) begin
          abort_d      = 1'b1;
          track_done_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (state_nxt == S_IDLE && state != S_IDLE) begin
      locked_d    = 1'b0;
      half_pend_d = 1'b0;
      window_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      cnt        <= '0;
      t_ref      <= '0;
      half_len   <= '0;
      half_pend  <= 1'b0;
      have_ref   <= 1'b0;
      zero_cnt   <= '0;
      window     <= '0;
      bit_cnt    <= '0;
      lrc_acc    <= '0;
      locked     <= 1'b0;
      char_data  <= '0;
      char_valid <= 1'b0;
      char_perr  <= 1'b0;
      track_done <= 1'b0;
      lrc_err    <= 1'b0;
      abort      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[1:0], f2f_in};
      cnt        <= cnt_d;
      t_ref      <= t_ref_d;
      half_len   <= half_len_d;
      half_pend  <= half_pend_d;
      have_ref   <= have_ref_d;
      zero_cnt   <= zero_cnt_d;
      window     <= window_d;
      bit_cnt    <= bit_cnt_d;
      lrc_acc    <= lrc_acc_d;
      locked     <= locked_d;
      char_data  <= char_data_d;
      char_valid <= char_valid_d;
      char_perr  <= char_perr_d;
      track_done <= track_done_d;
      lrc_err    <= lrc_err_d;
      abort      <= abort_d;
    end
  end

endmodule
